alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Upstream issue/operand stage for the `alu` block. It accepts instructions (`opcode`, `rs1`, `rs2`, `rd`) over a valid/ready handshake and reads operands from an internal 8×32 register file, forwarding the in-flight result when needed. It registers `a`/`b`/`opcode` into an EX stage that drives the ALU, then captures `result`/`zero` into a result register with its own valid/ready output. Register writeback happens when EX advances.

## Interface
- `DATA_W`, 32, operand/result width; must match ALU width.
- `NREGS`, 8, register count; power of two; `AW = log2(NREGS)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: instruction accepted when `in_valid && in_ready`.
- `in_opcode` in 3: ALU opcode, passed through unmodified.
- `in_rs1`, `in_rs2` in AW: source register indices.
- `in_rd` in AW: destination index; `rd == 0` means no write.
- `wr_en`, `wr_addr` [AW], `wr_data` [DATA_W] in: external register-load port.
- `alu_a`, `alu_b` out DATA_W; `alu_opcode` out 3: EX-stage registers, wired to the ALU.
- `alu_result` in DATA_W; `alu_zero` in 1: combinational ALU outputs.
- `res_valid` out 1; `res_ready` in 1: result handshake.
- `res_data` out DATA_W; `res_zero` out 1; `res_rd` out AW: registered result.

## Operation
- **Register file**
  - `r0` reads as 0 and is never written.
  - Reset clears all registers to 0.
- **EX stage**
  - Holds `ex_valid`, `ex_rd`, and the `alu_*` registers.
  - `ex_adv = ex_valid && (!res_valid || res_ready)`.
  - `in_ready = !ex_valid || ex_adv`, combinational; no dependency on `in_valid`.
- **On accept**
  - Latch `alu_opcode <= in_opcode`, `ex_rd <= in_rd`, `ex_valid <= 1`.
  - Operand read priority:
    1. Index 0 gives 0.
    2. Else, if `ex_adv` and `ex_rd == rs` and `ex_rd != 0`, use `alu_result` (bypass).
    3. Else, use the regfile value.
  - External writes in the same cycle are not bypassed; the read returns the old value.
- **Not accepted but EX advances**
  - `ex_valid <= 0`; the `alu_*` registers hold their values.
- **On `ex_adv`**
  - Result register loads: `res_data <= alu_result`, `res_zero <= alu_zero`, `res_rd <= ex_rd`, `res_valid <= 1`.
  - `rf[ex_rd] <= alu_result` if `ex_rd != 0`.
- **Result handshake**
  - `res_valid` clears on `res_ready` if no new `ex_adv` occurs that cycle.
  - Result outputs hold stable while `res_valid && !res_ready`.
- **External write**
  - `rf[wr_addr] <= wr_data` if `wr_en` and `wr_addr != 0`.
  - If the EX writeback targets the same register in the same cycle, the EX writeback wins.
- **Widths**
  - ALU arithmetic and overflow are owned by the ALU.
  - This stage does no width conversion; `DATA_W` passes through.

## Timing
- **Reset** (async assert; release sampled on `clk`): all outputs 0 (`in_ready` follows its equation), regfile cleared.
  - Reset mid-operation drops in-flight EX and result entries without writeback.
- **Latency:** accept at edge N; ALU sees operands in cycle N+1; `res_valid` rises after edge N+1; the result is readable from `rd` by an instruction accepted in cycle N+1 via bypass.
- **Throughput:** one instruction per cycle while `res_ready = 1`.
- **Backpressure:** with `res_valid && !res_ready`, EX stalls and `in_ready` falls in the same cycle; EX and result registers hold.
- **Back-to-back dependency:** no stall cycles; the bypass covers a distance of 1.
  - At distance 2 or more, the value is already in the regfile.
- **Simultaneous events:**
  - `res_ready` and a new `ex_adv` in the same cycle: the result register is overwritten and `res_valid` stays 1.
  - Accept and EX retire in the same cycle are both permitted.

## Test plan
- **Reset/idle:** assert `rst` mid-stream with `res_valid = 1` -> `res_valid = 0`, `in_ready = 1`, `alu_a = alu_b = 0`; reading `r1..r7` returns 0.
- **Load and add:** `wr r1 = 5`, `wr r2 = 7`; issue ADD (3'b000) `rd = 3`, `rs1 = 1`, `rs2 = 2` -> `res_data = 12`, `res_zero = 0`, `res_rd = 3`, one cycle after accept; then `rf[3] = 12`.
- **Dependency bypass:** ADD `r3 = r1 + r2`, then immediately ADD `r4 = r3 + r3` -> second result 24, no bubble, `in_ready` continuously 1.
- **r0 semantics:** ADD `rd = 0`, `rs1 = 1`, `rs2 = 0` with `r1 = 9` -> `res_data = 9`, `res_rd = 0`; a later read of `r0` returns 0.
- **Backpressure:** hold `res_ready = 0` for 3 cycles with 3 instructions queued -> exactly 2 in flight (EX + result), `in_ready = 0`, outputs stable; release -> results emerge in order, none lost or duplicated.
- **Write conflict:** `wr_en` to `r5 = 0xAAAA` in the same cycle as EX writeback to `r5 = 0x1234` -> `rf[5] = 0x1234`.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue/operand stage feeding an external combinational ALU: register file with
// distance-1 bypass, an EX register stage, and a result register with valid/ready.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic [AW-1:0]     res_rd
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready never depends on in_valid; res_* hold while res_valid && !res_ready.

  logic [DATA_W-1:0] rf [NREGS];
  logic              ex_valid;
  logic [AW-1:0]     ex_rd;
  logic              ex_adv;
  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign ex_adv   = ex_valid && (!res_valid || res_ready);
  assign in_ready = !ex_valid || ex_adv;
  assign accept   = in_valid && in_ready;

  // Bypass only when the EX result is actually retiring this cycle; a nonzero
  // source index matching ex_rd implies ex_rd is nonzero.
  always_comb begin
    op_a = rf[in_rs1];
    if (in_rs1 == '0)
      op_a = '0;
    else if (ex_adv && (ex_rd == in_rs1))
      op_a = alu_result;
  end

  always_comb begin
    op_b = rf[in_rs2];
    if (in_rs2 == '0)
      op_b = '0;
    else if (ex_adv && (ex_rd == in_rs2))
      op_b = alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_rd      <= in_rd;
      alu_a      <= op_a;
      alu_b      <= op_b;
      alu_opcode <= in_opcode;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_rd    <= '0;
    end else if (ex_adv) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_zero  <= alu_zero;
      res_rd    <= ex_rd;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // The EX writeback is assigned last so it wins over an external write to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (wr_en && (wr_addr != '0))
        rf[wr_addr] <= wr_data;
      if (ex_adv && (ex_rd != '0))
        rf[ex_rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: drives directed instructions, models the ALU, and
// checks results through an expected-value queue popped by a monitor.
module tb_alu_issue_stage;

  localparam int DATA_W = 32;
  localparam int AW     = 3;
  localparam int EW     = DATA_W + 1 + AW;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b011;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [AW-1:0]     in_rs1;
  logic [AW-1:0]     in_rs2;
  logic [AW-1:0]     in_rd;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic [AW-1:0]     res_rd;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.DATA_W(DATA_W), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_rd(res_rd)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in combinational ALU
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor / scoreboard: a result transfers on the edge following this sample
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got data=0x%0h zero=%0b rd=%0d with nothing expected",
                 res_data, res_zero, res_rd);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({res_data, res_zero, res_rd} !== e) begin
          errors++;
          $display("FAIL result: got data=0x%0h zero=%0b rd=%0d expected data=0x%0h zero=%0b rd=%0d",
                   res_data, res_zero, res_rd, e[EW-1 -: DATA_W], e[AW], e[AW-1:0]);
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic [DATA_W-1:0] exp_data,
                       input logic exp_zero, input bit no_stall);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    exp_q.push_back({exp_data, exp_zero, rd});
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("issue_timeout", 64'(n), 64'd0);
    if (no_stall) check("no_stall", 64'(n), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    res_ready = 1'b1;
    idle(2);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    rst = 1'b0;
    idle(1);

    // Reset mid-stream with a result pending
    do_write(3'd1, 32'h11);
    do_write(3'd7, 32'h77);
    res_ready = 1'b0;
    issue(OP_ADD, 3'd1, 3'd7, 3'd2, 32'h88, 1'b0, 1'b1);
    idle(1);
    check("pre_rst_res_valid", 64'(res_valid), 64'd1);
    check("pre_rst_res_data", 64'(res_data), 64'h88);
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_alu_a", 64'(alu_a), 64'd0);
    check("mid_rst_alu_b", 64'(alu_b), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    for (int k = 1; k < 8; k++) issue(OP_ADD, 3'(k), 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
    idle(2);

    // Load and add, with cycle-accurate latency
    do_write(3'd1, 32'd5);
    do_write(3'd2, 32'd7);
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 32'd12, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_res_valid_n1", 64'(res_valid), 64'd0);
    check("lat_alu_a", 64'(alu_a), 64'd5);
    check("lat_alu_b", 64'(alu_b), 64'd7);
    @(negedge clk);
    check("lat_res_valid_n2", 64'(res_valid), 64'd1);
    check("lat_res_data", 64'(res_data), 64'd12);
    @(posedge clk);
    #1;
    issue(OP_ADD, 3'd3, 3'd0, 3'd0, 32'd12, 1'b0, 1'b0);
    idle(2);

    // Back-to-back dependencies: distance 1 bypass and distance 2+ regfile
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 32'd12, 1'b0, 1'b1);
    issue(OP_ADD, 3'd3, 3'd3, 3'd4, 32'd24, 1'b0, 1'b1);
    issue(OP_ADD, 3'd4, 3'd1, 3'd5, 32'd29, 1'b0, 1'b1);
    issue(OP_ADD, 3'd3, 3'd4, 3'd6, 32'd36, 1'b0, 1'b1);
    issue(OP_SUB, 3'd6, 3'd6, 3'd7, 32'd0, 1'b1, 1'b1);
    idle(2);

    // r0 semantics: rd=0 result is delivered but never written or bypassed
    do_write(3'd1, 32'd9);
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 32'd9, 1'b0, 1'b1);
    issue(OP_ADD, 3'd0, 3'd0, 3'd0, 32'd0, 1'b1, 1'b1);
    idle(2);

    // Backpressure: two in flight, third waits, order preserved on release
    res_ready = 1'b0;
    fork
      begin
        issue(OP_OR,  3'd1, 3'd1, 3'd2, 32'd9,  1'b0, 1'b0);
        issue(OP_ADD, 3'd2, 3'd1, 3'd3, 32'd18, 1'b0, 1'b0);
        issue(OP_SUB, 3'd3, 3'd1, 3'd4, 32'd9,  1'b0, 1'b0);
      end
    join_none
    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_data", 64'(res_data), 64'd9);
      check("bp_alu_a", 64'(alu_a), 64'd9);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait fork;
    idle(3);

    // Write conflict: EX writeback beats a same-cycle external write
    do_write(3'd6, 32'h1234);
    issue(OP_ADD, 3'd6, 3'd0, 3'd5, 32'h1234, 1'b0, 1'b1);
    do_write(3'd5, 32'hAAAA);
    idle(2);
    issue(OP_ADD, 3'd5, 3'd0, 3'd0, 32'h1234, 1'b0, 1'b1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    idle(1);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
